session_ctrl: RTL
=================

SESSION_CTRL -- requirements
Module: session_ctrl

Interface
REQ-001 Parameter: PIN_W, default 16, PIN width in bits.
REQ-002 Parameter: MAX_TRIES, default 3, wrong-PIN attempts allowed per session (1..7).
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 card_in  input  1  card present in slot (level).
REQ-006 pin_valid  input  1  one-cycle strobe, pin_in valid.
REQ-007 pin_in  input  PIN_W  entered PIN.
REQ-008 stored_pin  input  PIN_W  PIN read from card, stable while card_in=1.
REQ-009 op_valid  input  1  one-cycle strobe, op_code valid.
REQ-010 op_code  input  2  0=withdraw, 1=deposit, 2=balance, 3=cancel.
REQ-011 op_done  input  1  one-cycle strobe from transaction unit, operation finished.
REQ-012 timeout  input  1  inactivity flag from the session timer.
REQ-013 timer_run  output  1  timer count enable (level).
REQ-014 timer_clr  output  1  one-cycle timer clear/restart pulse.
REQ-015 op_go  output  1  one-cycle launch strobe to transaction unit.
REQ-016 op_sel  output  2  registered operation code, valid from op_go until op_done.
REQ-017 card_eject  output  1  one-cycle eject command.
REQ-018 card_retain  output  1  one-cycle retain (swallow) command.
REQ-019 pin_err  output  1  one-cycle pulse on each wrong PIN.
REQ-020 state_o  output  3  current FSM state encoding, for debug.

Function
REQ-021 FSM states SHALL be IDLE=0, PIN=1, MENU=2, EXEC=3, EJECT=4, RETAIN=5.
REQ-022 IDLE: card_in=1 -> PIN, tries counter cleared, timer_clr pulsed same cycle as transition.
REQ-023 PIN: pin_valid with pin_in==stored_pin -> MENU, timer_clr pulsed.
REQ-024 PIN: pin_valid with mismatch -> pin_err pulsed, tries incremented, timer_clr pulsed; on reaching MAX_TRIES -> RETAIN (or EJECT, see REQ-036).
REQ-025 MENU: op_valid with op_code 0..2 -> EXEC, op_sel registered, op_go pulsed next cycle (one-cycle latency).
REQ-026 MENU: op_valid with op_code 3 -> EJECT.
REQ-027 EXEC: op_done -> MENU, timer_clr pulsed; timeout ignored in EXEC (timer_run=0).
REQ-028 EJECT: card_eject pulsed one cycle on entry; state held until card_in=0, then IDLE.
REQ-029 RETAIN: card_retain pulsed one cycle on entry, then IDLE on next cycle regardless of card_in.
REQ-030 timer_run SHALL be 1 in PIN and MENU only, 0 elsewhere.
REQ-031 timeout=1 in PIN or MENU -> EJECT; timeout has priority over same-cycle pin_valid/op_valid.
REQ-032 card_in falling in PIN, MENU or EXEC -> IDLE, no eject/retain pulse; in EXEC op_go never reissued.
REQ-033 Tries counter SHALL be ceil(log2(MAX_TRIES+1)) bits, saturating, never wrapping.
REQ-034 pin_valid/op_valid in states other than PIN/MENU SHALL be ignored.

Reset
REQ-035 rst=1 at clk edge -> state IDLE, tries=0, op_sel=0, all strobe outputs and timer_run 0 on the following cycle; reset mid-EXEC abandons the operation silently.

Configuration
REQ-036 Macro SESSION_RETAIN_EN: defined -> MAX_TRIES wrong PINs go to RETAIN; undefined -> go to EJECT, card_retain tied 0, RETAIN state unreachable.

Verification
REQ-037 rst, card_in=1, pin_valid with matching PIN 0x1234 -> state PIN then MENU, timer_clr pulsed on each transition.
REQ-038 Three wrong PINs (MAX_TRIES=3) -> three pin_err pulses, third followed by card_retain one-cycle pulse (macro defined) or card_eject (undefined).
REQ-039 MENU, op_valid op_code=2 -> op_go one cycle later, op_sel=2, timer_run=0; op_done -> MENU, timer_run=1.
REQ-040 MENU, timeout=1 same cycle as op_valid -> EJECT, no op_go, card_eject pulsed; card_in=0 -> IDLE.
REQ-041 rst asserted during EXEC -> next cycle state_o=0, all outputs 0; later op_done ignored.

Source files
------------

// File: rtl/session_ctrl.sv
// Card session controller: card insertion, PIN check with limited tries, menu/exec handshake, eject/retain.
// Define SESSION_RETAIN_EN to swallow the card after MAX_TRIES wrong PINs; otherwise the card is ejected.
module session_ctrl #(
    parameter int PIN_W     = 16,
    parameter int MAX_TRIES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin_in,
    input  logic [PIN_W-1:0] stored_pin,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic             op_done,
    input  logic             timeout,
    output logic             timer_run,
    output logic             timer_clr,
    output logic             op_go,
    output logic [1:0]       op_sel,
    output logic             card_eject,
    output logic             card_retain,
    output logic             pin_err,
    output logic [2:0]       state_o
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PIN    = 3'd1,
        MENU   = 3'd2,
        EXEC   = 3'd3,
        EJECT  = 3'd4,
        RETAIN = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
    logic [1:0]       op_sel_q, op_sel_d;
    logic             timer_run_q, timer_run_d;
    logic             timer_clr_q, timer_clr_d;
    logic             op_go_q, op_go_d;
    logic             card_eject_q, card_eject_d;
    logic             card_retain_q, card_retain_d;
    logic             pin_err_q, pin_err_d;

    // Saturating increment: the counter can never wrap past MAX_TRIES.
    assign tries_inc = (tries_q == TRY_W'(MAX_TRIES)) ? tries_q : tries_q + TRY_W'(1);

    always_comb begin
        state_d       = state_q;
        tries_d       = tries_q;
        op_sel_d      = op_sel_q;
        timer_clr_d   = 1'b0;
        op_go_d       = 1'b0;
        card_eject_d  = 1'b0;
        card_retain_d = 1'b0;
        pin_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (card_in) begin
                    state_d     = PIN;
                    tries_d     = '0;
                    timer_clr_d = 1'b1;
                end
            end
            PIN: begin
                if (!card_in) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d      = EJECT;
                    card_eject_d = 1'b1;
                end else if (pin_valid) begin
                    timer_clr_d = 1'b1;
                    if (pin_in == stored_pin) begin
                        state_d = MENU;
                    end else begin
                        pin_err_d = 1'b1;
                        tries_d   = tries_inc;
                        if (tries_inc == TRY_W'(MAX_TRIES)) begin
`ifdef SESSION_RETAIN_EN
                            state_d       = RETAIN;
                            card_retain_d = 1'b1;
`else
                            state_d      = EJECT;
                            card_eject_d = 1'b1;
`endif
                        end
                    end
                end
            end
            MENU: begin
                if (!card_in) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d      = EJECT;
                    card_eject_d = 1'b1;
                end else if (op_valid) begin
                    if (op_code == 2'd3) begin
                        state_d      = EJECT;
                        card_eject_d = 1'b1;
                    end else begin
                        state_d  = EXEC;
                        op_sel_d = op_code;
                        op_go_d  = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (!card_in) begin
                    state_d = IDLE;
                end else if (op_done) begin
                    state_d     = MENU;
                    timer_clr_d = 1'b1;
                end
            end
            EJECT: begin
                if (!card_in) begin
                    state_d = IDLE;
                end
            end
            RETAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Timer enable tracks the state being entered so it lines up with state_o.
        timer_run_d = (state_d == PIN) || (state_d == MENU);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tries_q       <= '0;
            op_sel_q      <= 2'd0;
            timer_run_q   <= 1'b0;
            timer_clr_q   <= 1'b0;
            op_go_q       <= 1'b0;
            card_eject_q  <= 1'b0;
            card_retain_q <= 1'b0;
            pin_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tries_q       <= tries_d;
            op_sel_q      <= op_sel_d;
            timer_run_q   <= timer_run_d;
            timer_clr_q   <= timer_clr_d;
            op_go_q       <= op_go_d;
            card_eject_q  <= card_eject_d;
            card_retain_q <= card_retain_d;
            pin_err_q     <= pin_err_d;
        end
    end

    assign state_o     = state_q;
    assign timer_run   = timer_run_q;
    assign timer_clr   = timer_clr_q;
    assign op_go       = op_go_q;
    assign op_sel      = op_sel_q;
    assign card_eject  = card_eject_q;
    assign card_retain = card_retain_q;
    assign pin_err     = pin_err_q;

endmodule
